mips_mem_access: RTL and testbench
==================================

# mips_mem_access

Load/store access unit between the MIPS core's memory stage and the word-addressed data RAM. The RAM has combinational read, single-cycle write, no byte enables, and little-endian byte lanes. This block accepts one load or store request at a time. It converts MIPS big-endian byte, halfword and word accesses into aligned word reads and writes, and performs read-modify-write for sub-word stores. It returns load data that is sign- or zero-extended.

## Interface
Parameters: none. Clock `clk`; reset `reset`, synchronous, active-high.

- `clk` input 1: rising-edge clock
- `reset` input 1: synchronous, active-high
- `req_valid` input 1: request present
- `req_ready` output 1: high only in IDLE; a request is accepted on `req_valid && req_ready`
- `req_op` input 4: `mem_op_t` — LB, LBU, LH, LHU, LW, SB, SH, SW
- `req_addr` input 32: byte address
- `req_wdata` input 32: store data; the low 8/16/32 bits are used
- `resp_valid` output 1: one-cycle completion pulse
- `resp_rdata` output 32: load result, valid with `resp_valid`; 0 for stores
- `resp_err` output 1: misaligned access, valid with `resp_valid`
- `data_address` output 32: `{addr[31:2],2'b00}` of the captured request
- `data_read` output 1: RAM read strobe
- `data_write` output 1: RAM write strobe
- `data_writedata` output 32: RAM write word, in memory lane order
- `data_readdata` input 32: RAM read word, combinational

## Operation
- **Lane mapping:** the byte at address 4k+n sits in memory lanes [8n+7:8n]. A CPU word equals `byteswap(memory word)`.
- **Request capture:** op, addr and wdata are registered on acceptance. Inputs are ignored outside IDLE.
- **Misalignment rule:** halfword with addr[0]=1 is misaligned; word with addr[1:0]≠0 is misaligned. On misalignment go to RESP with `resp_err`=1, `resp_rdata`=0, and no RAM strobes.
- **FSM states:** IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE → LOAD for a load.
  - IDLE → WRITE for SW.
  - IDLE → RMW_RD for SB/SH.
  - IDLE → RESP on error.
  - LOAD: `data_read`=1; the extracted and extended value is registered; → RESP.
  - RMW_RD: `data_read`=1; `data_readdata` is registered; → WRITE.
  - WRITE: `data_write`=1. `data_writedata` is the swapped wdata for SW, or the held word with only the addressed lanes replaced for SB/SH. → RESP.
  - RESP: `resp_valid`=1; → IDLE.
- **Extraction:** LB/LH sign-extend from bit 7/15 of the CPU-order value; LBU/LHU zero-extend.
- **Strobe gating:** `data_read` and `data_write` are decoded from state and gated with `!reset`.
- **Reset:** reset from any state returns to IDLE. A WRITE cycle with `reset` high commits nothing.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready`=1 after reset
  - `resp_valid`, `resp_err`, `data_read`, `data_write` = 0
  - `resp_rdata`, `data_address`, `data_writedata` = 0
- Latency counted from the accept edge:
  - loads: `resp_valid` in the 2nd cycle
  - SW: 2nd cycle
  - SB/SH: 3rd cycle
  - error: 1st cycle
- `req_ready` is low from the cycle after acceptance through RESP. It returns high in the cycle after RESP, so there is no back-to-back accept in the RESP cycle.
- No response backpressure: `resp_valid` is a single-cycle pulse.
- `data_address` is held stable throughout RMW_RD and WRITE.

## Structure
- Package `mips_mem_pkg`: `mem_op_t` enum, `mem_state_t` enum, and a `byteswap32` function.
- Sub-module `mem_lane_align` (combinational): takes addr[1:0], op, memory word and store data. It produces the extended load value and the merged write word.

## Test plan
RAM preloaded with word0 = 0x12345678 and word1 = 0xEEEE68AC (CPU order).
- **Reset:** hold `reset` 2 cycles → all outputs 0, `req_ready`=1.
- **LW:** LW addr 0 → `resp_rdata`=0x12345678 with `resp_valid` 2 cycles after accept; `data_read` high exactly 1 cycle.
- **Sub-word loads:**
  - LB addr 4 → 0xFFFFFFEE
  - LBU addr 4 → 0x000000EE
  - LH addr 6 → 0x000068AC
  - LHU addr 4 → 0x0000EEEE
- **SB with readback:** SB addr 2, wdata 0x000000AB → one `data_write` cycle with `data_writedata`=0x78AB3412, `resp_valid` in the 3rd cycle; a following LW addr 0 returns 0x1234AB78.
- **Misaligned:** LH addr 3 and SW addr 6 → `resp_err`=1 in the cycle after accept; `data_read` and `data_write` never asserted.
- **Reset during WRITE:** SH addr 0, wdata 0xBEEF, with `reset` asserted in the WRITE cycle → no write; after reset, LW addr 0 returns 0x12345678 and `req_ready`=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS load/store access unit.
// CPU words are big-endian; the RAM stores byte n of a word in lanes [8n+7:8n].
package mips_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } mem_state_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Undefined op encodings are reported as errors so they never touch the RAM.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH:  return a[0];
      OP_LW, OP_SW:          return (a != 2'b00);
      OP_LB, OP_LBU, OP_SB:  return 1'b0;
      default:               return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: extracts/extends load data and builds the
// merged RAM write word, working internally in CPU (big-endian) order.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_mem_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_write_word
);

  mem_op_t     w_op;
  logic [31:0] w_cpu;
  logic [31:0] w_new_cpu;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_op  = mem_op_t'(i_op);
  assign w_cpu = byteswap32(i_mem_word);

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = w_cpu[31:24];
      2'd1:    w_byte = w_cpu[23:16];
      2'd2:    w_byte = w_cpu[15:8];
      default: w_byte = w_cpu[7:0];
    endcase
    w_half = i_offset[1] ? w_cpu[15:0] : w_cpu[31:16];

    case (w_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'h000000, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'h0000, w_half};
      OP_LW:   o_load_data = w_cpu;
      default: o_load_data = 32'h00000000;
    endcase
  end

  // Sub-word stores replace only the addressed bytes of the held word.
  always_comb begin
    w_new_cpu = w_cpu;
    case (w_op)
      OP_SB: begin
        case (i_offset)
          2'd0:    w_new_cpu[31:24] = i_store_data[7:0];
          2'd1:    w_new_cpu[23:16] = i_store_data[7:0];
          2'd2:    w_new_cpu[15:8]  = i_store_data[7:0];
          default: w_new_cpu[7:0]   = i_store_data[7:0];
        endcase
      end
      OP_SH: begin
        if (i_offset[1]) w_new_cpu[15:0]  = i_store_data[15:0];
        else             w_new_cpu[31:16] = i_store_data[15:0];
      end
      OP_SW:   w_new_cpu = i_store_data;
      default: w_new_cpu = w_cpu;
    endcase
    o_write_word = byteswap32(w_new_cpu);
  end

endmodule

// File: rtl/mips_mem_access.sv
// Load/store access unit: one request at a time, converting MIPS byte/half/word
// accesses into aligned word reads and writes with read-modify-write for SB/SH.
module mips_mem_access
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  mem_state_t  r_state;
  mem_op_t     r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_held;
  logic [31:0] r_rdata;
  logic        r_err;

  mem_op_t     w_req_op;
  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_align_word;
  logic [31:0] w_load_data;
  logic [31:0] w_write_word;

  assign w_req_op     = mem_op_t'(req_op);
  assign w_accept     = req_valid && (r_state == ST_IDLE);
  assign w_misaligned = is_misaligned(w_req_op, req_addr[1:0]);
  // Loads steer the live RAM word; stores merge into the word held from RMW_RD.
  assign w_align_word = (r_state == ST_LOAD) ? data_readdata : r_held;

  mem_lane_align u_align (
    .i_offset     (r_addr[1:0]),
    .i_op         (r_op),
    .i_mem_word   (w_align_word),
    .i_store_data (r_wdata),
    .o_load_data  (w_load_data),
    .o_write_word (w_write_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LB;
      r_addr  <= 32'h00000000;
      r_wdata <= 32'h00000000;
      r_held  <= 32'h00000000;
      r_rdata <= 32'h00000000;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= w_req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= 32'h00000000;
            r_err   <= w_misaligned;
            if (w_misaligned) begin
              r_state <= ST_RESP;
            end else begin
              case (w_req_op)
                OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: r_state <= ST_LOAD;
                OP_SB, OP_SH:                        r_state <= ST_RMW_RD;
                OP_SW:                               r_state <= ST_WRITE;
                default:                             r_state <= ST_RESP;
              endcase
            end
          end
        end
        ST_LOAD: begin
          r_rdata <= w_load_data;
          r_state <= ST_RESP;
        end
        ST_RMW_RD: begin
          r_held  <= data_readdata;
          r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = (r_state == ST_IDLE);
  assign resp_valid     = (r_state == ST_RESP);
  assign resp_err       = (r_state == ST_RESP) && r_err;
  assign resp_rdata     = r_rdata;
  assign data_address   = {r_addr[31:2], 2'b00};
  // Strobes drop immediately with reset so an interrupted WRITE commits nothing.
  assign data_read      = !reset && ((r_state == ST_LOAD) || (r_state == ST_RMW_RD));
  assign data_write     = !reset && (r_state == ST_WRITE);
  assign data_writedata = (r_state == ST_WRITE) ? w_write_word : 32'h00000000;

endmodule

// File: tb/tb_mips_mem_access.sv
// Bench for mips_mem_access: byte-addressed big-endian reference memory model,
// per-cycle compare process, and directed requests with literal expectations.
module tb_mips_mem_access;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  always #5 clk = ~clk;

  mips_mem_access dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  // RAM in memory lane order (byte at 4k+n in lanes [8n+7:8n])
  logic [31:0] ram [0:15] = '{0: 32'h78563412, 1: 32'hAC68EEEE, default: 32'h00000000};
  assign data_readdata = ram[data_address[5:2]];
  always @(posedge clk) if (data_write) ram[data_address[5:2]] <= data_writedata;

  // Reference model: plain byte array indexed by byte address
  logic [7:0] ref_bytes [0:63] = '{0: 8'h12, 1: 8'h34, 2: 8'h56, 3: 8'h78,
                                   4: 8'hEE, 5: 8'hEE, 6: 8'h68, 7: 8'hAC, default: 8'h00};

  int n_checks = 0;
  int n_fail   = 0;

  mem_op_t     m_op    = OP_LB;
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;
  logic        m_store = 1'b0;
  logic        m_rdreq = 1'b0;
  int          m_lat   = 1;

  int   cyc    = 0;
  logic chk_en = 1'b0;

  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_wword = 32'h0;
  logic        last_err   = 1'b0;
  int          last_lat   = 0;
  int          n_rd       = 0;
  int          n_wr       = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_err(input mem_op_t op, input logic [31:0] addr);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr[0];
      OP_LW, OP_SW:         return addr[1:0] != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input mem_op_t op, input logic [31:0] addr);
    int a;
    logic [7:0] b0, b1, b2, b3;
    a  = int'(addr[5:0]);
    b0 = ref_bytes[a];
    b1 = ref_bytes[(a + 1) % 64];
    b2 = ref_bytes[(a + 2) % 64];
    b3 = ref_bytes[(a + 3) % 64];
    case (op)
      OP_LB:   return {{24{b0[7]}}, b0};
      OP_LBU:  return {24'h0, b0};
      OP_LH:   return {{16{b0[7]}}, b0, b1};
      OP_LHU:  return {16'h0, b0, b1};
      OP_LW:   return {b0, b1, b2, b3};
      default: return 32'h0;
    endcase
  endfunction

  // Memory word (lane order) that must result from applying the store
  function automatic logic [31:0] model_store_word(input mem_op_t op, input logic [31:0] addr,
                                                   input logic [31:0] wd);
    logic [7:0] w [0:3];
    int base, off;
    base = int'(addr[5:2]) * 4;
    off  = int'(addr[1:0]);
    for (int k = 0; k < 4; k++) w[k] = ref_bytes[base + k];
    case (op)
      OP_SB: w[off] = wd[7:0];
      OP_SH: begin w[off] = wd[15:8]; w[(off + 1) % 4] = wd[7:0]; end
      OP_SW: begin w[0] = wd[31:24]; w[1] = wd[23:16]; w[2] = wd[15:8]; w[3] = wd[7:0]; end
      default: ;
    endcase
    return {w[3], w[2], w[1], w[0]};
  endfunction

  // Transaction cycle counter and store commit into the reference model
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else if (cyc == 0) begin if (req_valid) cyc <= 1; end
    else if (cyc >= m_lat) cyc <= 0;
    else cyc <= cyc + 1;
    if (!reset && m_store && !m_err && cyc != 0 && cyc == m_lat - 1)
      for (int k = 0; k < 4; k++)
        ref_bytes[int'(m_addr[5:2]) * 4 + k] <= 8'(model_store_word(m_op, m_addr, m_wdata) >> (8 * k));
  end

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check32("req_ready", {31'h0, req_ready}, {31'h0, cyc == 0});
      check32("resp_valid", {31'h0, resp_valid}, {31'h0, cyc != 0 && cyc == m_lat});
      check32("data_read", {31'h0, data_read}, {31'h0, !reset && cyc == 1 && m_rdreq && !m_err});
      check32("data_write", {31'h0, data_write},
              {31'h0, !reset && m_store && !m_err && cyc != 0 && cyc == m_lat - 1});
      if (cyc != 0) check32("data_address", data_address, {m_addr[31:2], 2'b00});
      if (cyc != 0 && cyc == m_lat) begin
        check32("resp_rdata", resp_rdata, m_rdata);
        check32("resp_err", {31'h0, resp_err}, {31'h0, m_err});
        last_rdata <= resp_rdata;
        last_err   <= resp_err;
        last_lat   <= cyc;
      end
      if (!reset && m_store && !m_err && cyc != 0 && cyc == m_lat - 1) begin
        check32("data_writedata", data_writedata, model_store_word(m_op, m_addr, m_wdata));
        last_wword <= data_writedata;
      end
      if (cyc == 1) begin
        n_rd <= int'(data_read);
        n_wr <= int'(data_write);
      end else if (cyc != 0) begin
        n_rd <= n_rd + int'(data_read);
        n_wr <= n_wr + int'(data_write);
      end
    end
  end

  task automatic issue(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input int reset_at);
    @(negedge clk);
    m_op    = op;
    m_addr  = addr;
    m_wdata = wd;
    m_err   = model_err(op, addr);
    m_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    m_rdreq = !m_store || (op == OP_SB) || (op == OP_SH);
    m_lat   = m_err ? 1 : ((op == OP_SB) || (op == OP_SH)) ? 3 : 2;
    m_rdata = (m_err || m_store) ? 32'h0 : model_load(op, addr);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 4'd7;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 8; i++) begin
      if (cyc == 0) break;
      if (i == reset_at) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    if (cyc != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: transaction still active at cycle %0d, required completion", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check32("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check32("rst_data_read", {31'h0, data_read}, 32'h0);
    check32("rst_data_write", {31'h0, data_write}, 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_data_address", data_address, 32'h0);
    check32("rst_data_writedata", data_writedata, 32'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    issue(OP_LW, 32'd0, 32'h0, 0);
    check32("lw0_rdata", last_rdata, 32'h12345678);
    check32("lw0_latency", last_lat, 32'd2);
    check32("lw0_read_cycles", n_rd, 32'd1);

    issue(OP_LB, 32'd4, 32'h0, 0);
    check32("lb4", last_rdata, 32'hFFFFFFEE);
    issue(OP_LBU, 32'd4, 32'h0, 0);
    check32("lbu4", last_rdata, 32'h000000EE);
    issue(OP_LH, 32'd6, 32'h0, 0);
    check32("lh6", last_rdata, 32'h000068AC);
    issue(OP_LHU, 32'd4, 32'h0, 0);
    check32("lhu4", last_rdata, 32'h0000EEEE);

    issue(OP_LH, 32'd3, 32'h0, 0);
    check32("lh3_err", {31'h0, last_err}, 32'h1);
    check32("lh3_latency", last_lat, 32'd1);
    check32("lh3_strobes", n_rd + n_wr, 32'd0);
    issue(OP_SW, 32'd6, 32'h11223344, 0);
    check32("sw6_err", {31'h0, last_err}, 32'h1);
    check32("sw6_strobes", n_rd + n_wr, 32'd0);
    check32("sw6_rdata", last_rdata, 32'h0);

    issue(OP_SH, 32'd0, 32'h0000BEEF, 2);
    issue(OP_LW, 32'd0, 32'h0, 0);
    check32("lw0_after_reset", last_rdata, 32'h12345678);

    issue(OP_SB, 32'd2, 32'h000000AB, 0);
    check32("sb2_wword", last_wword, 32'h78AB3412);
    check32("sb2_latency", last_lat, 32'd3);
    check32("sb2_write_cycles", n_wr, 32'd1);
    check32("sb2_rdata", last_rdata, 32'h0);
    issue(OP_LW, 32'd0, 32'h0, 0);
    check32("lw0_after_sb", last_rdata, 32'h1234AB78);

    issue(OP_SW, 32'd4, 32'hCAFEBABE, 0);
    check32("sw4_wword", last_wword, 32'hBEBAFECA);
    issue(OP_LH, 32'd4, 32'h0, 0);
    check32("lh4_after_sw", last_rdata, 32'hFFFFCAFE);
    issue(OP_SH, 32'd6, 32'h00001234, 0);
    issue(OP_LW, 32'd4, 32'h0, 0);
    check32("lw4_after_sh", last_rdata, 32'hCAFE1234);
    issue(OP_LB, 32'd7, 32'h0, 0);
    check32("lb7", last_rdata, 32'h00000034);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
